// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- instruction fetch stage with a prefetch queue.
//
// Issues sequential fetch requests to instruction memory, queues the in-order
// responses in an FQ_DEPTH-entry FIFO and presents the head entry
// {pc_4, instr} to decode. A branch redirect flushes the queue and marks every
// outstanding request as "kill" so its late response is dropped.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   branch_taken, branch_target    redirect request / address
//   imem_req_valid/ready/addr      fetch request channel (valid/ready)
//   imem_rsp_valid/data            in-order response channel, no backpressure
//   id_valid/ready, id_pc_4/instr  head entry to decode (valid/ready)
//
// Build option: define FETCH_QUEUE_BYPASS_EN to let a live response reach
// decode in the same cycle it arrives when the queue is empty.

module fetch_queue_if #(
    parameter int unsigned          XLEN     = 32,
    parameter int unsigned          FQ_DEPTH = 4,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc_4,
    output logic [XLEN-1:0] id_instr
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    // kill only has to cover requests the memory can hold outstanding at once.
    localparam int KW = 8;
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(FQ_DEPTH);
    localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   pending_q, pending_d;
    logic [KW-1:0]   kill_q, kill_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] mem_pc4_q   [FQ_DEPTH];
    logic [XLEN-1:0] mem_pc4_d   [FQ_DEPTH];
    logic [XLEN-1:0] mem_instr_q [FQ_DEPTH];
    logic [XLEN-1:0] mem_instr_d [FQ_DEPTH];

    logic [CW:0]     occ;
    logic            req_valid;
    logic            req_fire;
    logic            rsp_live;
    logic            byp;
    logic            head_valid;
    logic            deq;
    logic            q_pop;
    logic            enq;
    logic [XLEN-1:0] entry_pc4;

    // ---------------- handshake / datapath decisions ----------------
    always_comb begin
        // Every live request holds a reserved slot, so the queue never overflows.
        occ       = {1'b0, count_q} + {1'b0, pending_q};
        req_valid = !rst && !branch_taken && (occ < DEPTH_C);
        req_fire  = req_valid && imem_req_ready;
        rsp_live  = imem_rsp_valid && (kill_q == '0);
        entry_pc4 = rsp_pc_q + FOUR;

`ifdef FETCH_QUEUE_BYPASS_EN
        byp = !rst && (count_q == '0) && rsp_live && !branch_taken;
`else
        byp = 1'b0;
`endif

        head_valid = !rst && ((count_q != '0) || byp);
        deq        = head_valid && id_ready && !branch_taken;
        q_pop      = deq && (count_q != '0);
        // A bypassed response that decode takes right away never enters the queue.
        enq        = rsp_live && !branch_taken && !(byp && id_ready);

        id_valid = head_valid;
        id_pc_4  = '0;
        id_instr = '0;
        if (head_valid) begin
            if (count_q != '0) begin
                id_pc_4  = mem_pc4_q[rd_ptr_q];
                id_instr = mem_instr_q[rd_ptr_q];
            end else begin
                id_pc_4  = entry_pc4;
                id_instr = imem_rsp_data;
            end
        end

        imem_req_valid = req_valid;
        imem_req_addr  = rst ? RESET_PC : pc_q;
    end

    // ---------------- next state ----------------
    always_comb begin
        pc_d      = pc_q;
        rsp_pc_d  = rsp_pc_q;
        count_d   = count_q;
        pending_d = pending_q;
        kill_d    = kill_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;

        if (branch_taken) begin
            pc_d      = branch_target;
            rsp_pc_d  = branch_target;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            // Everything still outstanding is doomed; a response arriving this
            // cycle is already dropped, so it is not counted.
            kill_d    = kill_q + KW'(pending_q) - KW'(imem_rsp_valid);
            pending_d = '0;
        end else begin
            if (req_fire)
                pc_d = pc_q + FOUR;
            if (imem_rsp_valid && !rsp_live)
                kill_d = kill_q - KW'(1);
            if (rsp_live)
                rsp_pc_d = entry_pc4;
            pending_d = pending_q + CW'(req_fire) - CW'(rsp_live);
            count_d   = count_q + CW'(enq) - CW'(q_pop);
            if (enq)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (q_pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_comb begin
        mem_pc4_d   = mem_pc4_q;
        mem_instr_d = mem_instr_q;
        if (enq) begin
            mem_pc4_d[wr_ptr_q]   = entry_pc4;
            mem_instr_d[wr_ptr_q] = imem_rsp_data;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            rsp_pc_q  <= RESET_PC;
            count_q   <= '0;
            pending_q <= '0;
            kill_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            kill_q    <= kill_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Queue storage is only read under count, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_pc4_q   <= mem_pc4_d;
        mem_instr_q <= mem_instr_d;
    end

endmodule

// File: tb/tb_fetch_queue_if.sv
module tb_fetch_queue_if;

    logic        clk;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc_4;
    logic [31:0] id_instr;

    fetch_queue_if #(.XLEN(32), .FQ_DEPTH(4), .RESET_PC(32'h100)) dut (
        .clk            (clk),
        .rst            (rst),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc_4        (id_pc_4),
        .id_instr       (id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    int          vectors = 0;
    int          errors  = 0;
    int          lat     = 1;
    int          cyc     = 0;
    mreq_t       memq[$];
    logic [31:0] expq[$];

    // Memory model: fixed latency, in order, data = ~address.
    always @(negedge clk) begin
        cyc = cyc + 1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (memq.size() > 0 && memq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~memq[0].addr;
            void'(memq.pop_front());
        end
    end

    // Scoreboard: expected entries pushed at request fire, popped at handshake.
    always @(negedge clk) begin
        mreq_t       m;
        logic [31:0] e;
        #3;
        if (rst) begin
            memq.delete();
            expq.delete();
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                m.due  = cyc + lat;
                m.addr = imem_req_addr;
                memq.push_back(m);
            end
            if (!id_valid) begin
                vectors++;
                if (id_pc_4 !== 32'h0 || id_instr !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_zero got pc4=%h instr=%h exp 0", id_pc_4, id_instr);
                end
            end
            if (branch_taken) begin
                expq.delete();
            end else begin
                if (id_valid && id_ready) begin
                    vectors++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra got pc4=%h instr=%h exp none", id_pc_4, id_instr);
                    end else begin
                        e = expq.pop_front();
                        if (id_pc_4 !== e + 32'd4 || id_instr !== ~e) begin
                            errors++;
                            $display("FAIL sb_entry got pc4=%h instr=%h exp pc4=%h instr=%h",
                                     id_pc_4, id_instr, e + 32'd4, ~e);
                        end
                    end
                end
                if (imem_req_valid && imem_req_ready)
                    expq.push_back(imem_req_addr);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_id(input string name, output logic got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            #1;
            got = id_valid;
        end
        if (!got) begin
            vectors++;
            errors++;
            $display("FAIL %s_timeout got id_valid=0 exp 1", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; branch_taken = 1'b0; branch_target = '0;
        imem_req_ready = 1'b1; id_ready = 1'b0; lat = 1;
        repeat (3) step();
        #1;
        vectors += 3;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
        if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL rst_req_addr got %h exp 100", imem_req_addr); end
        step();
        rst = 1'b0;
        #1;
        vectors += 2;
        if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got %b exp 1", imem_req_valid); end
        if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL first_req_addr got %h exp 100", imem_req_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        logic        got;
        id_ready = 1'b1;
        wait_id("stream", got);
        if (got) begin
            exp = 32'h104;
            repeat (6) begin
                vectors++;
                if (id_valid !== 1'b1 || id_pc_4 !== exp) begin
                    errors++;
                    $display("FAIL stream_seq got valid=%b pc4=%h exp valid=1 pc4=%h", id_valid, id_pc_4, exp);
                end
                exp += 32'd4;
                step();
                #1;
            end
        end
    endtask

    task automatic test_stall_fill();
        int n;
        id_ready = 1'b0;
        repeat (10) step();
        #1;
        vectors += 2;
        if (id_valid !== 1'b1) begin errors++; $display("FAIL stall_id_valid got %b exp 1", id_valid); end
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid got %b exp 0", imem_req_valid); end
        imem_req_ready = 1'b0;
        id_ready = 1'b1;
        n = 0;
        repeat (8) begin
            if (id_valid) n++;
            step();
            #1;
        end
        vectors++;
        if (n != 4) begin errors++; $display("FAIL stall_drain_count got %0d exp 4", n); end
        lat = 3;
        imem_req_ready = 1'b1;
    endtask

    task automatic test_redirect_inflight();
        logic got;
        id_ready = 1'b1;
        repeat (8) step();
        branch_taken = 1'b1;
        branch_target = 32'h400;
        step();
        branch_taken = 1'b0;
        #1;
        vectors += 2;
        if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL redir_req_valid got %b exp 1", imem_req_valid); end
        if (imem_req_addr !== 32'h400) begin errors++; $display("FAIL redir_req_addr got %h exp 400", imem_req_addr); end
        wait_id("redir", got);
        if (got) begin
            vectors++;
            if (id_pc_4 !== 32'h404 || id_instr !== ~32'h400) begin
                errors++;
                $display("FAIL redir_first got pc4=%h instr=%h exp pc4=404 instr=%h", id_pc_4, id_instr, ~32'h400);
            end
        end
    endtask

    task automatic test_redirect_coincident();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            #1;
            got = id_valid && imem_rsp_valid;
        end
        if (!got) begin
            vectors++;
            errors++;
            $display("FAIL coinc_setup_timeout got 0 exp 1");
        end
        branch_taken = 1'b1;
        branch_target = 32'h800;
        step();
        branch_taken = 1'b0;
        wait_id("coinc", got);
        if (got) begin
            vectors++;
            if (id_pc_4 !== 32'h804 || id_instr !== ~32'h800) begin
                errors++;
                $display("FAIL coinc_first got pc4=%h instr=%h exp pc4=804 instr=%h", id_pc_4, id_instr, ~32'h800);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_seq [3];
        logic        got;
        exp_seq[0] = 32'hFFFF_FFFC; exp_seq[1] = 32'h0; exp_seq[2] = 32'h4;
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFF8;
        imem_req_ready = 1'b0;
        step();
        branch_taken = 1'b0;
        repeat (5) step();
        lat = 1;
        imem_req_ready = 1'b1;
        wait_id("wrap", got);
        if (got) begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (id_valid !== 1'b1 || id_pc_4 !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL wrap_seq%0d got valid=%b pc4=%h exp valid=1 pc4=%h", i, id_valid, id_pc_4, exp_seq[i]);
                end
                step();
                #1;
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] a;
        imem_req_ready = 1'b0;
        id_ready = 1'b1;
        repeat (6) step();
        step();
        imem_req_ready = 1'b1;
        #1;
        a = imem_req_addr;
        step();
        imem_req_ready = 1'b0;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        vectors++;
        if (id_valid !== 1'b1 || id_pc_4 !== a + 32'd4) begin
            errors++;
            $display("FAIL bypass_same got valid=%b pc4=%h exp valid=1 pc4=%h", id_valid, id_pc_4, a + 32'd4);
        end
        step();
        #1;
        vectors++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL bypass_after got valid=%b exp 0", id_valid); end
`else
        vectors++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL nobyp_same got valid=%b exp 0", id_valid); end
        step();
        #1;
        vectors++;
        if (id_valid !== 1'b1 || id_pc_4 !== a + 32'd4) begin
            errors++;
            $display("FAIL nobyp_next got valid=%b pc4=%h exp valid=1 pc4=%h", id_valid, id_pc_4, a + 32'd4);
        end
`endif
        repeat (4) step();
        #1;
        vectors += 2;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL end_idle got valid=%b exp 0", id_valid); end
        if (expq.size() != 0) begin errors++; $display("FAIL end_sb_left got %0d exp 0", expq.size()); end
    endtask

    initial begin
        rst = 1'b1; branch_taken = 1'b0; branch_target = '0;
        imem_req_ready = 1'b0; id_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall_fill();
        test_redirect_inflight();
        test_redirect_coincident();
        test_wrap();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
